lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit in the MEM stage; the initiator side of the byte-addressed 1 KiB data memory port (addr, writeData, writeEnable, readEnable, readData).
- Accepts one load/store request at a time from the pipeline and drives the memory port.
- Sign- or zero-extends load data.
- Memory writes only full 4-byte words, so SB/SH are done as read-modify-write (RMW).
- Flags misaligned, out-of-range and illegal requests without touching memory.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; a request is legal only if word_addr+3 < MEM_BYTES.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE; request accepted when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; low bits used for B/H
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned, out of range or illegal funct3
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors
- mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  XLEN  full word to write
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  XLEN  memory read data; valid before the rising edge ending the cycle in which mem_re is high

Behaviour:
- States: IDLE, RD, WR, RESP. All outputs are decoded from registered state and registered request fields; there are no combinational paths from req_* to mem_*.
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0; latched request fields cleared. An RMW in flight is abandoned and no write occurs.
- IDLE: on accept, latch addr, wdata, funct3 and store. Error check:
  - H/HU/SH need addr[0]=0.
  - W needs addr[1:0]=0.
  - Illegal: funct3 011/110/111, or store with 100/101.
  - Out of range: aligned addr + 3 >= MEM_BYTES.
  - On error, go to RESP with err=1 and no mem_re/mem_we in any cycle.
  - Otherwise: loads and SB/SH go to RD; SW goes to WR.
- RD: mem_re=1, mem_addr=aligned. At the closing edge, capture mem_rdata into rbuf. Load goes to RESP; SB/SH go to WR.
- WR: mem_we=1, mem_addr=aligned.
  - SW: mem_wdata = wdata.
  - SB: rbuf with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rbuf with halfword lane addr[1] replaced by wdata[15:0].
  - Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - LB/LH: select lane by addr and sign-extend.
  - LBU/LHU: select lane and zero-extend.
  - LW: rbuf unchanged.
- Latency from the accept edge to resp_valid:
  - LW/LB/LH/LBU/LHU: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- req_ready=0 in RD, WR and RESP. req_valid is ignored outside IDLE; the pipeline must hold the request and stall on !req_ready.
- A new request can be accepted in the IDLE cycle immediately after RESP; no back-to-back acceptance in the RESP cycle.
- mem_we and mem_re are never high in the same cycle. Each is high for at most one cycle per request.

Test Plan:
- LW:
  - Reset, then LW addr 0x0.
  - Response: mem_re high for one cycle with mem_addr=0; resp_valid 2 cycles after accept; resp_rdata=0x00000005; resp_err=0.
- SB with load-back:
  - Reset, then SB addr 0x1, wdata 0x00000080: RD then WR; mem_wdata=0x00008005; resp_valid 3 cycles after accept.
  - Then LW 0x0 returns 0x00008005.
  - LB 0x1 returns 0xFFFFFF80; LBU 0x1 returns 0x00000080.
- SH:
  - After the SB scenario, SH addr 0x2, wdata 0x1234ABCD: mem_wdata=0xABCD8005.
  - Then LH 0x2 returns 0xFFFFABCD; LHU 0x2 returns 0x0000ABCD.
- Errors:
  - LW 0x2: resp_err=1, resp_rdata=0.
  - SH 0x3: resp_err=1.
  - LW 0x400: resp_err=1.
  - funct3=011: resp_err=1.
  - Each errored request responds 1 cycle after accept, with mem_re=mem_we=0 throughout.
- Reset mid-RMW:
  - Assert reset during the RD cycle of SB 0x0, wdata 0xFF.
  - Response: mem_we never asserts; state returns to IDLE asynchronously; req_ready=1.
  - A later LW 0x0 returns the unmodified 0x00000005.
- Handshake:
  - Hold req_valid high with two queued LW requests.
  - Response: second request accepted only in the IDLE cycle after the first RESP; no mem activity during RESP; two resp_valid pulses 3 cycles apart.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store unit (MEM stage): initiator side of a word-wide data memory port.
// Accepts one request at a time, validates it, performs loads, full-word
// stores and read-modify-write sub-word stores, and returns one response pulse.
module lsu_mem_initiator #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned XLEN      = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic            resp_err,
   output logic [XLEN-1:0] resp_rdata,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            mem_we,
   output logic            mem_re,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q,  addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            store_q, store_d;
   logic            err_q,   err_d;
   logic [XLEN-1:0] rbuf_q,  rbuf_d;

   logic            req_misaligned;
   logic            req_illegal;
   logic            req_out_of_range;
   logic            req_error;
   logic [XLEN:0]   req_last_byte;

   logic [XLEN-1:0] aligned_addr;
   logic [4:0]      lane_shift;
   logic [XLEN-1:0] rbuf_shifted;

   assign aligned_addr = {addr_q[XLEN-1:2], 2'b00};
   assign lane_shift   = {addr_q[1:0], 3'b000};
   assign rbuf_shifted = rbuf_q >> lane_shift;

   // Classify the incoming request; only meaningful while accepting in IDLE.
   always_comb begin
      req_last_byte    = {1'b0, req_addr[XLEN-1:2], 2'b00} + (XLEN+1)'(3);
      req_out_of_range = (req_last_byte >= (XLEN+1)'(MEM_BYTES));
      req_misaligned   = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                         ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
      req_illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
      req_error        = req_misaligned || req_illegal || req_out_of_range;
   end

   // State and latched request registers; reset abandons any RMW in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         err_q    <= 1'b0;
         rbuf_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         store_q  <= store_d;
         err_q    <= err_d;
         rbuf_q   <= rbuf_d;
      end
   end

   // Next-state logic: accept/route in IDLE, capture read data in RD.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      store_d  = store_q;
      err_d    = err_q;
      rbuf_d   = rbuf_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               store_d  = req_store;
               err_d    = req_error;
               if (req_error)
                  state_d = RESP;
               else if (req_store && req_funct3 == 3'b010)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            rbuf_d  = mem_rdata;
            state_d = store_q ? WR : RESP;
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded purely from registered state and latched request fields.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      unique case (state_q)
         IDLE: req_ready = 1'b1;
         RD: begin
            mem_re   = 1'b1;
            mem_addr = aligned_addr;
         end
         WR: begin
            mem_we   = 1'b1;
            mem_addr = aligned_addr;
            // Sub-word stores merge the new lane into the word read in RD.
            unique case (funct3_q[1:0])
               2'b00:   mem_wdata = (rbuf_q & ~(XLEN'(8'hFF) << lane_shift)) |
                                    (XLEN'(wdata_q[7:0]) << lane_shift);
               2'b01:   mem_wdata = (rbuf_q & ~(XLEN'(16'hFFFF) << lane_shift)) |
                                    (XLEN'(wdata_q[15:0]) << lane_shift);
               default: mem_wdata = wdata_q;
            endcase
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !store_q) begin
               unique case (funct3_q)
                  3'b000:  resp_rdata = {{(XLEN-8){rbuf_shifted[7]}}, rbuf_shifted[7:0]};
                  3'b001:  resp_rdata = {{(XLEN-16){rbuf_shifted[15]}}, rbuf_shifted[15:0]};
                  3'b100:  resp_rdata = {{(XLEN-8){1'b0}}, rbuf_shifted[7:0]};
                  3'b101:  resp_rdata = {{(XLEN-16){1'b0}}, rbuf_shifted[15:0]};
                  default: resp_rdata = rbuf_q;
               endcase
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 1 KiB word memory model.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;

   logic [31:0] mem [256];
   logic        mem_init;

   int unsigned tests = 0;
   int unsigned fails = 0;

   lsu_mem_initiator #(
      .MEM_BYTES(1024),
      .XLEN(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_store(req_store),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_err(resp_err),
      .resp_rdata(resp_rdata),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write at the rising edge.
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h0000_0005;
         mem[1] <= 32'hCAFE_F00D;
      end else if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and check latency, response and memory-port activity.
   task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_nre, input int exp_nwe, input logic [31:0] exp_wd);
      int          lat;
      int          nre;
      int          nwe;
      logic        overlap;
      logic        err_seen;
      logic [31:0] rd_seen;
      logic [31:0] wd_seen;
      logic [31:0] addr_seen;
      lat = 0; nre = 0; nwe = 0; overlap = 1'b0;
      err_seen = 1'bx; rd_seen = 'x; wd_seen = 'x; addr_seen = 'x;
      @(negedge clk);
      chk({tag, ".ready_before"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (mem_re && mem_we) overlap = 1'b1;
         if (mem_re) begin nre++; addr_seen = mem_addr; end
         if (mem_we) begin nwe++; addr_seen = mem_addr; wd_seen = mem_wdata; end
         if (resp_valid) begin
            lat = n; err_seen = resp_err; rd_seen = resp_rdata;
            if (mem_re || mem_we) overlap = 1'b1;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".err"}, {31'b0, err_seen}, {31'b0, exp_err});
      chk({tag, ".rdata"}, rd_seen, exp_rd);
      chk({tag, ".n_re"}, 32'(nre), 32'(exp_nre));
      chk({tag, ".n_we"}, 32'(nwe), 32'(exp_nwe));
      chk({tag, ".overlap"}, {31'b0, overlap}, 32'd0);
      if (exp_nre + exp_nwe > 0) chk({tag, ".mem_addr"}, addr_seen, {a[31:2], 2'b00});
      if (exp_nwe > 0) chk({tag, ".mem_wdata"}, wd_seen, exp_wd);
      @(negedge clk);
      chk({tag, ".pulse_end"}, {30'b0, resp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0] pulses;
      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset.ready", {31'b0, req_ready}, 32'd1);
      chk("reset.resp", {30'b0, resp_valid, resp_err}, 32'd0);
      chk("reset.rdata", resp_rdata, 32'd0);
      chk("reset.mem_ctl", {30'b0, mem_re, mem_we}, 32'd0);
      chk("reset.mem_addr", mem_addr, 32'd0);
      chk("reset.mem_wdata", mem_wdata, 32'd0);
      mem_init = 1'b0; reset = 1'b0;

      do_req("lw0",    1'b0, 3'b010, 32'h0,   32'h0,        2, 1'b0, 32'h0000_0005, 1, 0, 32'h0);
      do_req("sb1",    1'b1, 3'b000, 32'h1,   32'h0000_0080, 3, 1'b0, 32'h0,        1, 1, 32'h0000_8005);
      do_req("lw0b",   1'b0, 3'b010, 32'h0,   32'h0,        2, 1'b0, 32'h0000_8005, 1, 0, 32'h0);
      do_req("lb1",    1'b0, 3'b000, 32'h1,   32'h0,        2, 1'b0, 32'hFFFF_FF80, 1, 0, 32'h0);
      do_req("lbu1",   1'b0, 3'b100, 32'h1,   32'h0,        2, 1'b0, 32'h0000_0080, 1, 0, 32'h0);
      do_req("sh2",    1'b1, 3'b001, 32'h2,   32'h1234_ABCD, 3, 1'b0, 32'h0,        1, 1, 32'hABCD_8005);
      do_req("lh2",    1'b0, 3'b001, 32'h2,   32'h0,        2, 1'b0, 32'hFFFF_ABCD, 1, 0, 32'h0);
      do_req("lhu2",   1'b0, 3'b101, 32'h2,   32'h0,        2, 1'b0, 32'h0000_ABCD, 1, 0, 32'h0);
      do_req("sw8",    1'b1, 3'b010, 32'h8,   32'hDEAD_BEEF, 2, 1'b0, 32'h0,        0, 1, 32'hDEAD_BEEF);
      do_req("lw8",    1'b0, 3'b010, 32'h8,   32'h0,        2, 1'b0, 32'hDEAD_BEEF, 1, 0, 32'h0);
      do_req("lb_b",   1'b0, 3'b000, 32'hB,   32'h0,        2, 1'b0, 32'hFFFF_FFDE, 1, 0, 32'h0);
      do_req("lh_a",   1'b0, 3'b001, 32'hA,   32'h0,        2, 1'b0, 32'hFFFF_DEAD, 1, 0, 32'h0);
      do_req("lw3fc",  1'b0, 3'b010, 32'h3FC, 32'h0,        2, 1'b0, 32'h0,        1, 0, 32'h0);
      do_req("e_lw2",  1'b0, 3'b010, 32'h2,   32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);
      do_req("e_sh3",  1'b1, 3'b001, 32'h3,   32'hFFFF,     1, 1'b1, 32'h0,        0, 0, 32'h0);
      do_req("e_lw400",1'b0, 3'b010, 32'h400, 32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);
      do_req("e_f011", 1'b0, 3'b011, 32'h0,   32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);
      do_req("e_sbu",  1'b1, 3'b100, 32'h0,   32'h55,       1, 1'b1, 32'h0,        0, 0, 32'h0);
      do_req("e_lh1",  1'b0, 3'b001, 32'h1,   32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);

      // Reset during the RD cycle of an SB must abandon the write.
      @(negedge clk);
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'hFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rst_rmw.in_rd", {31'b0, mem_re}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_rmw.async_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rmw.async_ctl", {30'b0, mem_re, mem_we}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rst_rmw.no_we", {30'b0, mem_we, resp_valid}, 32'd0);
      end
      reset = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("rst_rmw.idle_no_we", {31'b0, mem_we}, 32'd0);
      end
      do_req("rst_rmw.lw0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 1'b0, 32'h0000_0005, 1, 0, 32'h0);

      // Two queued loads with req_valid held high.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = '0;
      @(posedge clk);
      #1 req_addr = 32'h4;
      pulses = 2'b00;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 2) begin
            chk("hs.resp1", {31'b0, resp_valid}, 32'd1);
            chk("hs.rdata1", resp_rdata, 32'h0000_0005);
            chk("hs.ready_in_resp", {31'b0, req_ready}, 32'd0);
            chk("hs.no_mem_in_resp", {30'b0, mem_re, mem_we}, 32'd0);
            pulses[0] = resp_valid;
         end else if (n == 3) begin
            chk("hs.idle_ready", {31'b0, req_ready}, 32'd1);
            chk("hs.idle_quiet", {29'b0, mem_re, mem_we, resp_valid}, 32'd0);
         end else if (n == 4) begin
            chk("hs.rd2_re", {31'b0, mem_re}, 32'd1);
            chk("hs.rd2_addr", mem_addr, 32'h4);
            req_valid = 1'b0;
         end else if (n == 5) begin
            chk("hs.resp2", {31'b0, resp_valid}, 32'd1);
            chk("hs.rdata2", resp_rdata, 32'hCAFE_F00D);
            chk("hs.no_mem_in_resp2", {30'b0, mem_re, mem_we}, 32'd0);
            pulses[1] = resp_valid;
         end else begin
            chk("hs.gap", {31'b0, resp_valid}, 32'd0);
         end
      end
      chk("hs.two_pulses", {30'b0, pulses}, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
